// File: rtl/tron_pkg.sv
// Shared definitions for the light-cycle game: heading codes, turn codes
// and the heading rotation helper used by direction control and the engine.
package tron_pkg;

  localparam logic [1:0] DIREITA  = 2'd0;
  localparam logic [1:0] BAIXO    = 2'd1;
  localparam logic [1:0] ESQUERDA = 2'd2;
  localparam logic [1:0] CIMA     = 2'd3;

  localparam logic GIRO_H  = 1'b0;  // clockwise, +1
  localparam logic GIRO_AH = 1'b1;  // anticlockwise, -1

  // Rotate a heading by one quarter turn; 2-bit arithmetic wraps naturally.
  function automatic logic [1:0] gira(input logic [1:0] sentido, input logic giro);
    logic [1:0] r;
    if (giro == GIRO_AH) begin
      r = sentido - 2'd1;
    end else begin
      r = sentido + 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_tecla.sv
// One push-button: two-flop synchronizer, stability counter and a
// press (falling edge of the debounced level) indicator.
module debounce_tecla #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic tecla,
  output logic queda
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE_CYCLES - 1);

  logic sinc1_r;
  logic sinc2_r;
  logic estavel_r;
  logic estavel_ant_r;
  logic [CW-1:0] cont_r;

  // Bring the asynchronous button into the clock domain (idle = released).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sinc1_r <= 1'b1;
      sinc2_r <= 1'b1;
    end else begin
      sinc1_r <= tecla;
      sinc2_r <= sinc1_r;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estavel_r     <= 1'b1;
      estavel_ant_r <= 1'b1;
      cont_r        <= '0;
    end else begin
      estavel_ant_r <= estavel_r;
      if (sinc2_r == estavel_r) begin
        cont_r <= '0;
      end else if (cont_r == LIMITE) begin
        estavel_r <= sinc2_r;
        cont_r    <= '0;
      end else begin
        cont_r <= cont_r + CW'(1);
      end
    end
  end

  // High for the single cycle right after the debounced level fell.
  assign queda = estavel_ant_r & ~estavel_r;

endmodule

// File: rtl/controle_direcao.sv
// Direction control: debounces the four buttons, converts presses into
// relative turns, queues up to two turns per player and applies one per step.
module controle_direcao
  import tron_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES    = 1000000,
  parameter logic [1:0] SENTIDO_INICIAL_J1 = DIREITA,
  parameter logic [1:0] SENTIDO_INICIAL_J2 = ESQUERDA
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       reiniciar,
  input  logic [3:0] KEY,
  input  logic       passo,
  output logic [1:0] sentido_j1,
  output logic [1:0] sentido_j2,
  output logic [3:0] tecla_pulso,
  output logic [1:0] descarte
);

  logic [3:0] queda_s;
  logic [1:0] anti_s;   // per player: anticlockwise key accepted
  logic [1:0] hor_s;    // per player: clockwise key accepted
  logic [3:0] pulso_r;

  for (genvar k = 0; k < 4; k++) begin : g_tecla
    debounce_tecla #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (CLOCK_50),
      .reset(reset),
      .tecla(KEY[k]),
      .queda(queda_s[k])
    );
  end

  assign anti_s = {queda_s[1], queda_s[3]};
  assign hor_s  = {queda_s[0], queda_s[2]};

  // Press pulses, suppressed during a round restart.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pulso_r <= 4'b0000;
    end else if (reiniciar) begin
      pulso_r <= 4'b0000;
    end else begin
      pulso_r <= queda_s;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_jog
    localparam logic [1:0] INICIAL = (p == 0) ? SENTIDO_INICIAL_J1 : SENTIDO_INICIAL_J2;

    logic [1:0] cont_r;
    logic [1:0] cont_s;
    logic [1:0] fila_r;    // [0] is the head, [1] the second entry
    logic [1:0] fila_s;
    logic [1:0] sentido_r;
    logic [1:0] sentido_s;
    logic       descarte_r;
    logic       descarte_s;
    logic       push_s;
    logic       pop_s;
    logic       giro_s;

    // Opposite keys on the same cycle cancel out and push nothing.
    assign push_s = anti_s[p] ^ hor_s[p];
    assign giro_s = anti_s[p] ? GIRO_AH : GIRO_H;
    assign pop_s  = passo & (cont_r != 2'd0);

    // Queue bookkeeping and heading update for one player.
    always_comb begin
      cont_s     = cont_r;
      fila_s     = fila_r;
      sentido_s  = sentido_r;
      descarte_s = 1'b0;
      if (pop_s) begin
        sentido_s = gira(sentido_r, fila_r[0]);
      end else begin
        sentido_s = sentido_r;
      end
      case (cont_r)
        2'd0: begin
          if (push_s) begin
            fila_s[0] = giro_s;
            cont_s    = 2'd1;
          end else begin
            cont_s = 2'd0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            fila_s[0] = giro_s;
          end else if (pop_s) begin
            cont_s = 2'd0;
          end else if (push_s) begin
            fila_s[1] = giro_s;
            cont_s    = 2'd2;
          end else begin
            cont_s = cont_r;
          end
        end
        2'd2: begin
          if (push_s && pop_s) begin
            fila_s[0] = fila_r[1];
            fila_s[1] = giro_s;
          end else if (pop_s) begin
            fila_s[0] = fila_r[1];
            cont_s    = 2'd1;
          end else if (push_s) begin
            descarte_s = 1'b1;
          end else begin
            cont_s = cont_r;
          end
        end
        default: begin
          cont_s = 2'd0;
        end
      endcase
    end

    // Queue, heading and drop-pulse registers; restart clears the round.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        cont_r     <= 2'd0;
        fila_r     <= 2'b00;
        sentido_r  <= INICIAL;
        descarte_r <= 1'b0;
      end else if (reiniciar) begin
        cont_r     <= 2'd0;
        fila_r     <= 2'b00;
        sentido_r  <= INICIAL;
        descarte_r <= 1'b0;
      end else begin
        cont_r     <= cont_s;
        fila_r     <= fila_s;
        sentido_r  <= sentido_s;
        descarte_r <= descarte_s;
      end
    end
  end

  assign sentido_j1  = g_jog[0].sentido_r;
  assign sentido_j2  = g_jog[1].sentido_r;
  assign descarte    = {g_jog[1].descarte_r, g_jog[0].descarte_r};
  assign tecla_pulso = pulso_r;

endmodule
